// File: rtl/mesh_inject_arbiter.sv
`default_nettype none
`ifndef MESH_W
`define MESH_W 32
`endif
// ============================================================================
// mesh_inject_arbiter: credit-limited round-robin share of a router local port
// Revision: 1.0
// ============================================================================
module mesh_inject_arbiter #(
  parameter int W               = `MESH_W,
  parameter int X_SIZE          = 8,
  parameter int Y_SIZE          = 8,
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 4,
  localparam int XW = $clog2(X_SIZE),
  localparam int YW = $clog2(Y_SIZE),
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  input  logic [NUM_REQ*XW-1:0] i_req_dst_x,
  input  logic [NUM_REQ*YW-1:0] i_req_dst_y,
  input  logic [NUM_REQ*W-1:0]  i_req_payload,
  output logic [NUM_REQ-1:0]    o_req_ready,
  output logic                  o_l_valid,
  output logic [XW-1:0]         o_l_dst_x,
  output logic [YW-1:0]         o_l_dst_y,
  output logic [W-1:0]          o_l_payload,
  input  logic                  i_l_ready,
  input  logic                  i_resp_valid,
  input  logic [IW-1:0]         i_resp_idx,
  output logic                  o_credit_err
);

  localparam logic [CW-1:0] MAX_C  = CW'(MAX_OUTSTANDING);
  localparam logic [IW:0]   NREQ_C = (IW+1)'(NUM_REQ);
  localparam logic [IW-1:0] LAST_C = IW'(NUM_REQ - 1);

  logic [NUM_REQ-1:0][CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0]              rr_ptr_q, rr_ptr_d;
  logic                       l_valid_q, l_valid_d;
  logic [XW-1:0]              l_dst_x_q, l_dst_x_d;
  logic [YW-1:0]              l_dst_y_q, l_dst_y_d;
  logic [W-1:0]               l_payload_q, l_payload_d;
  logic                       credit_err_q, credit_err_d;

  logic [NUM_REQ-1:0] elig, grant, inc_v, dec_v;
  logic [IW-1:0]      grant_idx;
  logic [IW:0]        scan;
  logic               load, accept, ret_ok;
  logic [XW-1:0]      sel_x;
  logic [YW-1:0]      sel_y;
  logic [W-1:0]       sel_payload;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = i_req_valid[i] && (cnt_q[i] < MAX_C);
    end
  end

  // Scan from the farthest offset down so the closest eligible index to rr_ptr wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    scan      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (scan >= NREQ_C) begin
        scan = scan - NREQ_C;
      end
      if (elig[scan[IW-1:0]]) begin
        grant                 = '0;
        grant[scan[IW-1:0]]   = 1'b1;
        grant_idx             = scan[IW-1:0];
      end
    end
  end

  assign load        = !l_valid_q || i_l_ready;
  assign o_req_ready = (load && !rst) ? grant : '0;
  assign accept      = |o_req_ready;

  always_comb begin
    sel_x       = '0;
    sel_y       = '0;
    sel_payload = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_x       = i_req_dst_x[i*XW +: XW];
        sel_y       = i_req_dst_y[i*YW +: YW];
        sel_payload = i_req_payload[i*W +: W];
      end
    end
  end

  always_comb begin
    l_valid_d   = l_valid_q;
    l_dst_x_d   = l_dst_x_q;
    l_dst_y_d   = l_dst_y_q;
    l_payload_d = l_payload_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept) begin
      l_valid_d   = 1'b1;
      l_dst_x_d   = sel_x;
      l_dst_y_d   = sel_y;
      l_payload_d = sel_payload;
      rr_ptr_d    = (grant_idx == LAST_C) ? '0 : grant_idx + 1'b1;
    end else if (l_valid_q && i_l_ready) begin
      l_valid_d = 1'b0;
    end

    // A return against an empty or nonexistent counter is dropped and flagged.
    inc_v  = '0;
    dec_v  = '0;
    ret_ok = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      inc_v[i] = accept && grant[i];
      dec_v[i] = i_resp_valid && (i_resp_idx == IW'(i)) && (cnt_q[i] != '0);
      ret_ok   = ret_ok | dec_v[i];
      cnt_d[i] = cnt_q[i] + CW'(inc_v[i]) - CW'(dec_v[i]);
    end
    credit_err_d = credit_err_q || (i_resp_valid && !ret_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      rr_ptr_q     <= '0;
      l_valid_q    <= 1'b0;
      l_dst_x_q    <= '0;
      l_dst_y_q    <= '0;
      l_payload_q  <= '0;
      credit_err_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      l_valid_q    <= l_valid_d;
      l_dst_x_q    <= l_dst_x_d;
      l_dst_y_q    <= l_dst_y_d;
      l_payload_q  <= l_payload_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign o_l_valid    = l_valid_q;
  assign o_l_dst_x    = l_dst_x_q;
  assign o_l_dst_y    = l_dst_y_q;
  assign o_l_payload  = l_payload_q;
  assign o_credit_err = credit_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mesh_inject_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mesh_inject_arbiter: directed self-checking bench with a behavioural model
// Revision: 1.0
// ============================================================================
module tb_mesh_inject_arbiter;
  localparam int W = 32, N = 4, MAXO = 4, XW = 3, YW = 3, IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    i_req_valid = '0;
  logic [N*XW-1:0] i_req_dst_x = '0;
  logic [N*YW-1:0] i_req_dst_y = '0;
  logic [N*W-1:0]  i_req_payload = '0;
  logic            i_l_ready = 1'b0;
  logic            i_resp_valid = 1'b0;
  logic [IW-1:0]   i_resp_idx = '0;
  logic [N-1:0]    o_req_ready;
  logic            o_l_valid;
  logic [XW-1:0]   o_l_dst_x;
  logic [YW-1:0]   o_l_dst_y;
  logic [W-1:0]    o_l_payload;
  logic            o_credit_err;

  always #5 clk = ~clk;

  mesh_inject_arbiter #(.W(W), .X_SIZE(8), .Y_SIZE(8), .NUM_REQ(N), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_dst_x(i_req_dst_x), .i_req_dst_y(i_req_dst_y),
    .i_req_payload(i_req_payload), .o_req_ready(o_req_ready),
    .o_l_valid(o_l_valid), .o_l_dst_x(o_l_dst_x), .o_l_dst_y(o_l_dst_y),
    .o_l_payload(o_l_payload), .i_l_ready(i_l_ready),
    .i_resp_valid(i_resp_valid), .i_resp_idx(i_resp_idx), .o_credit_err(o_credit_err)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-requester credit counts, a pointer, and a one-deep output slot.
  int          m_cnt[N];
  int          m_rr;
  bit          m_valid, m_err;
  int          m_x, m_y;
  logic [W-1:0] m_pay;
  int          dut_acc[N];
  int          dut_seq[$];

  always @(negedge clk) begin
    int g, j;
    logic [N-1:0] er;
    if (rst) begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_rr = 0; m_valid = 0; m_err = 0; m_x = 0; m_y = 0; m_pay = '0;
      chk("rst_ready", o_req_ready, 0);
      chk("rst_valid", o_l_valid, 0);
      chk("rst_err", o_credit_err, 0);
      chk("rst_payload", o_l_payload, 0);
    end else begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        j = (m_rr + k) % N;
        if (g < 0 && i_req_valid[j] && m_cnt[j] < MAXO) g = j;
      end
      er = '0;
      if ((!m_valid || i_l_ready) && g >= 0) er[g] = 1'b1;
      chk("ready", o_req_ready, er);
      chk("l_valid", o_l_valid, m_valid);
      chk("l_dst_x", o_l_dst_x, m_x);
      chk("l_dst_y", o_l_dst_y, m_y);
      chk("l_payload", o_l_payload, m_pay);
      chk("credit_err", o_credit_err, m_err);
      for (int i = 0; i < N; i++) begin
        if (o_req_ready[i] && i_req_valid[i]) begin
          dut_acc[i]++;
          dut_seq.push_back(i);
        end
      end
      if (i_resp_valid) begin
        if (int'(i_resp_idx) >= N || m_cnt[i_resp_idx] == 0) m_err = 1;
        else m_cnt[i_resp_idx]--;
      end
      if (er != '0) begin
        m_valid = 1;
        m_x   = int'(i_req_dst_x[g*XW +: XW]);
        m_y   = int'(i_req_dst_y[g*YW +: YW]);
        m_pay = i_req_payload[g*W +: W];
        m_cnt[g]++;
        m_rr = (g + 1) % N;
      end else if (m_valid && i_l_ready) begin
        m_valid = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int x, input int y, input logic [W-1:0] p);
    i_req_dst_x[i*XW +: XW] = XW'(x);
    i_req_dst_y[i*YW +: YW] = YW'(y);
    i_req_payload[i*W +: W] = p;
    i_req_valid[i] = 1'b1;
  endtask

  task automatic do_reset();
    i_req_valid = '0;
    i_resp_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int s0, a0;
    // Reset: ready must stay low even with every requester valid.
    for (int i = 0; i < N; i++) set_req(i, i, i, W'(i + 1));
    i_l_ready = 1'b1;
    step();
    chk("lit_rst_ready", o_req_ready, 4'b0000);
    chk("lit_rst_valid", o_l_valid, 0);
    chk("lit_rst_x", o_l_dst_x, 0);
    chk("lit_rst_err", o_credit_err, 0);
    i_req_valid = '0;
    rst = 1'b0;
    step();

    // Single requester.
    set_req(0, 3, 1, 32'hA5);
    #1 chk("lit_single_ready", o_req_ready, 4'b0001);
    step();
    i_req_valid = '0;
    chk("lit_single_valid", o_l_valid, 1);
    chk("lit_single_x", o_l_dst_x, 3);
    chk("lit_single_y", o_l_dst_y, 1);
    chk("lit_single_payload", o_l_payload, 32'hA5);
    chk("lit_single_cnt0", m_cnt[0], 1);
    do_reset();

    // Round-robin with immediate returns.
    s0 = dut_seq.size();
    for (int i = 0; i < N; i++) set_req(i, i + 1, 7 - i, W'(32'h100 + i));
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin
        i_resp_valid = 1'b1;
        i_resp_idx = IW'((c - 1) % N);
      end
      step();
      chk("lit_rr_no_gap", o_l_valid, 1);
    end
    i_req_valid = '0;
    i_resp_valid = 1'b0;
    chk("lit_rr_count", dut_seq.size() - s0, 12);
    for (int k = 0; k < 12; k++) begin
      if (s0 + k < dut_seq.size()) chk("lit_rr_order", dut_seq[s0 + k], k % N);
    end
    do_reset();

    // Credit exhaustion on requester 1.
    a0 = dut_acc[1];
    set_req(1, 2, 2, 32'h55);
    repeat (8) step();
    chk("lit_credit_4acc", dut_acc[1] - a0, 4);
    chk("lit_credit_blocked", o_req_ready, 4'b0000);
    chk("lit_credit_cnt1", m_cnt[1], 4);
    i_resp_valid = 1'b1;
    i_resp_idx = 2'd1;
    #1 chk("lit_credit_no_bypass", o_req_ready, 4'b0000);
    step();
    i_resp_valid = 1'b0;
    #1 chk("lit_credit_next_cycle", o_req_ready, 4'b0010);
    step();
    chk("lit_credit_reblocked", o_req_ready, 4'b0000);
    repeat (3) step();
    chk("lit_credit_5acc", dut_acc[1] - a0, 5);
    do_reset();

    // Backpressure holds the beat and blocks all readies.
    set_req(0, 2, 4, 32'h11);
    i_l_ready = 1'b0;
    #1 chk("lit_bp_first", o_req_ready, 4'b0001);
    step();
    i_req_valid[0] = 1'b0;
    set_req(2, 5, 6, 32'h22);
    repeat (5) begin
      #1;
      chk("lit_bp_ready", o_req_ready, 4'b0000);
      chk("lit_bp_valid", o_l_valid, 1);
      chk("lit_bp_payload", o_l_payload, 32'h11);
      chk("lit_bp_x", o_l_dst_x, 2);
      step();
    end
    chk("lit_bp_cnt0", m_cnt[0], 1);
    i_l_ready = 1'b1;
    #1 chk("lit_bp_release", o_req_ready, 4'b0100);
    step();
    i_req_valid = '0;
    chk("lit_bp_next_payload", o_l_payload, 32'h22);
    chk("lit_bp_next_xy", {o_l_dst_x, o_l_dst_y}, {3'd5, 3'd6});
    do_reset();

    // Same-cycle accept and return on requester 2.
    set_req(2, 1, 1, 32'h33);
    step();
    step();
    chk("lit_sim_cnt2_pre", m_cnt[2], 2);
    i_resp_valid = 1'b1;
    i_resp_idx = 2'd2;
    #1 chk("lit_sim_ready", o_req_ready, 4'b0100);
    step();
    i_resp_valid = 1'b0;
    chk("lit_sim_cnt2", m_cnt[2], 2);
    a0 = dut_acc[2];
    repeat (5) step();
    chk("lit_sim_remaining", dut_acc[2] - a0, 2);
    do_reset();

    // Spurious return, then reset while a beat is held.
    i_resp_valid = 1'b1;
    i_resp_idx = 2'd3;
    step();
    i_resp_valid = 1'b0;
    chk("lit_err_set", o_credit_err, 1);
    chk("lit_err_cnt3", m_cnt[3], 0);
    a0 = dut_acc[3];
    set_req(3, 6, 2, 32'h77);
    repeat (6) step();
    chk("lit_err_cnt3_dut", dut_acc[3] - a0, 4);
    chk("lit_err_sticky", o_credit_err, 1);
    i_req_valid = '0;
    i_resp_valid = 1'b1;
    i_resp_idx = 2'd3;
    step();
    i_resp_valid = 1'b0;
    set_req(3, 6, 2, 32'h78);
    i_l_ready = 1'b0;
    step();
    chk("lit_midrst_held", o_l_valid, 1);
    rst = 1'b1;
    #1;
    chk("lit_midrst_valid", o_l_valid, 0);
    chk("lit_midrst_err", o_credit_err, 0);
    chk("lit_midrst_ready", o_req_ready, 4'b0000);
    chk("lit_midrst_payload", o_l_payload, 0);
    step();
    rst = 1'b0;
    i_l_ready = 1'b1;
    a0 = dut_acc[3];
    repeat (6) step();
    chk("lit_midrst_credits", dut_acc[3] - a0, 4);
    i_req_valid = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/mesh_inject_arbiter.md
# mesh_inject_arbiter

Shares the local injection port of one mesh router among NUM_REQ requesters, typically the job PEs in a mesh tile that issue match requests. Each requester may have at most MAX_OUTSTANDING requests in flight. Responses returned on the router's local output release that requester's credit. Winners are chosen round-robin among requesters that hold a credit, and each winning beat is registered once before it reaches the router local input.

## Interface
Parameters:
- W, default `MESH_W: payload width.
- X_SIZE, default 8: mesh columns; XW = $clog2(X_SIZE).
- Y_SIZE, default 8: mesh rows; YW = $clog2(Y_SIZE).
- NUM_REQ, default 4: requester count (≥2); IW = $clog2(NUM_REQ).
- MAX_OUTSTANDING, default 4: credits per requester (≥1); CW = $clog2(MAX_OUTSTANDING+1).

Ports:
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req_valid  in  NUM_REQ  per-requester request valid.
- i_req_dst_x  in  NUM_REQ*XW  destination x; requester i occupies bits [i*XW +: XW].
- i_req_dst_y  in  NUM_REQ*YW  destination y; packed the same way.
- i_req_payload  in  NUM_REQ*W  payloads; packed the same way.
- o_req_ready  out  NUM_REQ  accept strobe; at most one bit high.
- o_l_valid  out  1  beat to router local input is valid.
- o_l_dst_x  out  XW  destination x of the beat.
- o_l_dst_y  out  YW  destination y of the beat.
- o_l_payload  out  W  payload of the beat.
- i_l_ready  in  1  router local-input ready.
- i_resp_valid  in  1  one response delivered, which returns one credit.
- i_resp_idx  in  IW  requester that owns the returned credit.
- o_credit_err  out  1  sticky error flag (conditions below).

## Operation
- State per requester i: cnt[i] (CW bits) counts requests in flight. State per block: rr_ptr (IW bits), a one-entry output register (valid, dst_x, dst_y, payload), and o_credit_err.
- Eligibility: requester i is eligible when i_req_valid[i] && cnt[i] < MAX_OUTSTANDING.
- Grant: pick the first eligible index searching upward from rr_ptr, with modulo-NUM_REQ wrap. The grant is one-hot, or zero when no requester is eligible.
- Load condition: load = !o_l_valid || i_l_ready, meaning the output register is empty or draining this cycle.
- Handshake: o_req_ready[i] = load && grant[i]. A request is accepted when i_req_valid[i] && o_req_ready[i].
- On accept:
  - capture dst_x, dst_y and payload into the output register and set its valid bit;
  - increment cnt[i];
  - set rr_ptr to (i+1) mod NUM_REQ.
- Draining: if o_l_valid && i_l_ready and nothing is accepted that cycle, clear the output register valid bit. Data bits hold their value.
- Credit return: on i_resp_valid, decrement cnt[i_resp_idx].
- Same-cycle increment and decrement on one requester leave cnt unchanged.
- A return while cnt[i_resp_idx]==0 is ignored (cnt stays 0) and sets o_credit_err.
- i_resp_idx ≥ NUM_REQ is ignored and also sets o_credit_err.
- o_credit_err clears only on reset.
- Ineligible requesters never see ready. A requester at MAX_OUTSTANDING is skipped, and rr_ptr does not move for it.
- Requesters must hold valid and their data stable until accepted. The block never drops or duplicates a beat.

## Timing
- Reset (asynchronous, immediate): o_l_valid=0, o_l_dst_x=0, o_l_dst_y=0, o_l_payload=0, all cnt=0, rr_ptr=0, o_credit_err=0. o_req_ready is all-zero while rst is high.
- Reset mid-operation: any held beat and all in-flight credits are discarded. Responses arriving after reset release are treated like any others: a return while cnt==0 sets o_credit_err, so the system must flush the mesh together with this block.
- Latency: a request accepted at edge T drives o_l_valid from T+1.
- Throughput: one beat per cycle while i_l_ready stays high.
- o_req_ready is combinational from i_req_valid, cnt, rr_ptr, o_l_valid and i_l_ready. It has no path from i_resp_valid; a returned credit becomes usable in the cycle after the return.
- Outputs o_l_* come directly from registers. They hold stable while o_l_valid && !i_l_ready.

## Test plan
- Single requester: after reset, req0 valid to (x=3, y=1) with payload 0xA5 and i_l_ready=1. Expected: o_req_ready=4'b0001 in the same cycle, o_l_valid with dst (3,1) and payload 0xA5 one cycle later, cnt[0]=1.
- Round-robin fairness: all four requesters valid continuously, i_l_ready=1, responses returned immediately. Expected: grants in order 0,1,2,3,0,… with one beat per cycle and no gaps.
- Credit exhaustion: MAX_OUTSTANDING=4, req1 valid, no responses. Expected: exactly 4 accepts, then o_req_ready[1]=0. After one response with i_resp_idx=1, exactly one further accept, and only in the following cycle.
- Backpressure: i_l_ready=0 for 5 cycles while a beat is held. Expected: o_l_* stable, no o_req_ready, cnt unchanged. After i_l_ready=1, the next winner is loaded in the same cycle.
- Simultaneous events: accept on req2 and a response with idx=2 in the same cycle from cnt[2]=2. Expected: cnt[2] stays 2.
- Errors and reset: a response with idx=3 while cnt[3]=0 sets o_credit_err and cnt[3] stays 0. Asserting rst while o_l_valid=1 immediately clears o_l_valid, all counts and o_credit_err.
